// File: rtl/gsm_pkg.sv
// Shared constants for the GSM response parser: response codes, ASCII bytes and FSM encoding.
// Used by gsm_line_classifier and gsm_resp_parser.
package gsm_pkg;

  localparam logic [2:0] RESP_NONE       = 3'd0;
  localparam logic [2:0] RESP_OK         = 3'd1;
  localparam logic [2:0] RESP_ERROR      = 3'd2;
  localparam logic [2:0] RESP_RING       = 3'd3;
  localparam logic [2:0] RESP_NO_CARRIER = 3'd4;
  localparam logic [2:0] RESP_CLIP       = 3'd5;
  localparam logic [2:0] RESP_COLP       = 3'd6;
  localparam logic [2:0] RESP_OTHER      = 3'd7;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_QUOTE = 8'h22;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LINE  = 3'd1;
  localparam logic [2:0] S_CLASS = 3'd2;
  localparam logic [2:0] S_NUM   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Longest keyword the classifier inspects ("NO CARRIER").
  localparam int CMP_BYTES = 10;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

endpackage

// File: rtl/gsm_line_classifier.sv
// Combinational keyword match on the head of a received line; a truncated
// line is always reported as RESP_OTHER.
module gsm_line_classifier
  import gsm_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic [8*CMP_BYTES-1:0] i_head,
  input  logic [LEN_W-1:0]       i_len,
  input  logic                   i_trunc,
  output logic [2:0]             o_code
);

  logic [7:0] w_b [CMP_BYTES];
  logic       w_ok;
  logic       w_error;
  logic       w_ring;
  logic       w_no_carrier;
  logic       w_clip;
  logic       w_colp;

  always_comb begin
    for (int k = 0; k < CMP_BYTES; k++) begin
      w_b[k] = i_head[8*k +: 8];
    end
  end

  assign w_ok    = (i_len == LEN_W'(2)) && (w_b[0] == "O") && (w_b[1] == "K");
  assign w_ring  = (i_len == LEN_W'(4)) && (w_b[0] == "R") && (w_b[1] == "I")
                && (w_b[2] == "N") && (w_b[3] == "G");
  assign w_error = (i_len >= LEN_W'(5)) && (w_b[0] == "E") && (w_b[1] == "R")
                && (w_b[2] == "R") && (w_b[3] == "O") && (w_b[4] == "R");
  assign w_no_carrier = (i_len >= LEN_W'(10))
                && (w_b[0] == "N") && (w_b[1] == "O") && (w_b[2] == " ")
                && (w_b[3] == "C") && (w_b[4] == "A") && (w_b[5] == "R")
                && (w_b[6] == "R") && (w_b[7] == "I") && (w_b[8] == "E")
                && (w_b[9] == "R");
  assign w_clip  = (i_len >= LEN_W'(6)) && (w_b[0] == "+") && (w_b[1] == "C")
                && (w_b[2] == "L") && (w_b[3] == "I") && (w_b[4] == "P")
                && (w_b[5] == ":");
  assign w_colp  = (i_len >= LEN_W'(6)) && (w_b[0] == "+") && (w_b[1] == "C")
                && (w_b[2] == "O") && (w_b[3] == "L") && (w_b[4] == "P")
                && (w_b[5] == ":");

  always_comb begin
    // NOTE: default first so every path assigns o_code and no latch is inferred.
    o_code = RESP_OTHER;
    if (!i_trunc) begin
      if (w_ok)              o_code = RESP_OK;
      else if (w_error)      o_code = RESP_ERROR;
      else if (w_ring)       o_code = RESP_RING;
      else if (w_no_carrier) o_code = RESP_NO_CARRIER;
      else if (w_clip)       o_code = RESP_CLIP;
      else if (w_colp)       o_code = RESP_COLP;
    end
  end

endmodule

// File: rtl/gsm_resp_parser.sv
// GSM modem response parser: line assembly, classification, +CLIP/+COLP number
// capture and a per-command response watchdog. Macro GSM_ECHO_FILTER_EN drops "AT"/"at" echo lines.
module gsm_resp_parser
  import gsm_pkg::*;
#(
  parameter int          LINE_MAX    = 32,
  parameter int          NUM_DIGITS  = 11,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  input  logic                    cmd_sent,
  output logic                    resp_valid,
  output logic [2:0]              resp_code,
  output logic [8*NUM_DIGITS-1:0] number,
  output logic                    number_valid,
  output logic                    resp_timeout,
  output logic                    rx_overrun
);

  localparam int LEN_W = $clog2(LINE_MAX + 1);
  localparam int IDX_W = $clog2(LINE_MAX);
  localparam int DIG_W = $clog2(NUM_DIGITS + 1);

  logic [2:0]              r_state;
  logic [7:0]              r_buf [LINE_MAX];
  logic [LEN_W-1:0]        r_len;
  logic                    r_trunc;
  logic [IDX_W-1:0]        r_scan_idx;
  logic                    r_open;
  logic [DIG_W-1:0]        r_dig_cnt;
  logic [8*NUM_DIGITS-1:0] r_num_shadow;
  logic [2:0]              r_code;
  logic                    r_resp_valid;
  logic [2:0]              r_resp_code;
  logic [8*NUM_DIGITS-1:0] r_number;
  logic                    r_number_valid;
  logic                    r_rx_overrun;
  logic                    r_wd_armed;
  logic [31:0]             r_wd_cnt;

  logic                    w_data_byte;
  logic                    w_buf_we;
  logic [IDX_W-1:0]        w_buf_idx;
  logic [8*CMP_BYTES-1:0]  w_head;
  logic [2:0]              w_code;
  logic                    w_echo;
  logic [7:0]              w_scan_byte;
  logic                    w_scan_last;
  logic                    w_scan_stop;
  logic                    w_open_next;
  logic [DIG_W-1:0]        w_dig_next;
  logic [8*NUM_DIGITS-1:0] w_num_next;
  logic                    w_wd_expire;
  logic                    w_wd_clear;

  assign w_data_byte = rx_done && (rx_data != CH_CR) && (rx_data != CH_LF);

  always_comb begin
    w_buf_we  = 1'b0;
    w_buf_idx = '0;
    if (r_state == S_IDLE) begin
      w_buf_we = w_data_byte;
    end else if (r_state == S_LINE) begin
      w_buf_we  = w_data_byte && (r_len < LEN_W'(LINE_MAX));
      w_buf_idx = r_len[IDX_W-1:0];
    end
  end

  // NOTE: the line buffer is plain storage with no reset; r_len says which bytes are meaningful.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_buf_idx] <= rx_data;
  end

  always_comb begin
    w_head = '0;
    for (int k = 0; k < CMP_BYTES; k++) begin
      w_head[8*k +: 8] = r_buf[k];
    end
  end

  gsm_line_classifier #(
    .LEN_W (LEN_W)
  ) u_classifier (
    .i_head  (w_head),
    .i_len   (r_len),
    .i_trunc (r_trunc),
    .o_code  (w_code)
  );

`ifdef GSM_ECHO_FILTER_EN
  assign w_echo = (r_len >= LEN_W'(2))
               && (((r_buf[0] == "A") && (r_buf[1] == "T"))
                || ((r_buf[0] == "a") && (r_buf[1] == "t")));
`else
  assign w_echo = 1'b0;
`endif

  // Number scan: one buffer byte per cycle; the final digit is folded into
  // w_num_next so it is published on the same edge the scan stops.
  assign w_scan_last = (LEN_W'(r_scan_idx) + LEN_W'(1)) >= r_len;

  always_comb begin
    w_scan_byte = r_buf[r_scan_idx];
    w_open_next = r_open;
    w_dig_next  = r_dig_cnt;
    w_num_next  = r_num_shadow;
    w_scan_stop = w_scan_last;
    if (!r_open) begin
      if (w_scan_byte == CH_QUOTE) w_open_next = 1'b1;
    end else if (w_scan_byte == CH_QUOTE) begin
      w_scan_stop = 1'b1;
    end else if (is_digit(w_scan_byte)) begin
      w_num_next[8*r_dig_cnt +: 8] = w_scan_byte;
      w_dig_next = r_dig_cnt + DIG_W'(1);
      if (w_dig_next == DIG_W'(NUM_DIGITS)) w_scan_stop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_trunc        <= 1'b0;
      r_scan_idx     <= '0;
      r_open         <= 1'b0;
      r_dig_cnt      <= '0;
      r_num_shadow   <= '0;
      r_code         <= RESP_NONE;
      r_resp_valid   <= 1'b0;
      r_resp_code    <= RESP_NONE;
      r_number       <= '0;
      r_number_valid <= 1'b0;
      r_rx_overrun   <= 1'b0;
    end else begin
      r_resp_valid   <= 1'b0;
      r_number_valid <= 1'b0;
      r_rx_overrun   <= rx_done && ((r_state == S_CLASS) || (r_state == S_NUM)
                                 || (r_state == S_DONE));
      case (r_state)
        S_IDLE: begin
          if (w_data_byte) begin
            r_len   <= LEN_W'(1);
            r_trunc <= 1'b0;
            r_state <= S_LINE;
          end
        end
        S_LINE: begin
          if (rx_done) begin
            if (rx_data == CH_LF) begin
              r_state <= S_CLASS;
            end else if (rx_data != CH_CR) begin
              if (r_len < LEN_W'(LINE_MAX)) r_len <= r_len + LEN_W'(1);
              else                          r_trunc <= 1'b1;
            end
          end
        end
        S_CLASS: begin
          r_code       <= w_code;
          r_scan_idx   <= '0;
          r_open       <= 1'b0;
          r_dig_cnt    <= '0;
          r_num_shadow <= '0;
          if (w_echo) begin
            r_len   <= '0;
            r_state <= S_IDLE;
          end else if ((w_code == RESP_CLIP) || (w_code == RESP_COLP)) begin
            r_state <= S_NUM;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_code  <= w_code;
            r_state      <= S_DONE;
          end
        end
        S_NUM: begin
          r_open       <= w_open_next;
          r_dig_cnt    <= w_dig_next;
          r_num_shadow <= w_num_next;
          r_scan_idx   <= r_scan_idx + IDX_W'(1);
          if (w_scan_stop) begin
            r_resp_valid   <= 1'b1;
            r_resp_code    <= r_code;
            r_number       <= w_num_next;
            r_number_valid <= (w_dig_next != '0);
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_len   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Watchdog: a fresh cmd_sent always wins over a disarm in the same cycle.
  assign w_wd_expire = r_wd_armed && (r_wd_cnt == (TIMEOUT_CYC - 32'd1));
  assign w_wd_clear  = r_resp_valid && (r_resp_code != RESP_OTHER);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd_armed <= 1'b0;
      r_wd_cnt   <= '0;
    end else if (cmd_sent) begin
      r_wd_armed <= 1'b1;
      r_wd_cnt   <= '0;
    end else if (w_wd_clear || w_wd_expire) begin
      r_wd_armed <= 1'b0;
    end else if (r_wd_armed) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_code    = r_resp_code;
  assign number       = r_number;
  assign number_valid = r_number_valid;
  assign resp_timeout = w_wd_expire;
  assign rx_overrun   = r_rx_overrun;

endmodule
